// File: rtl/alu_pkg.sv
// Shared ALU types for the mul/div scheduling path.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_t;

    localparam int unsigned MUL_LAT_DEFAULT = 3;

endpackage

// File: rtl/muldiv_sched.sv
// EX-stage sequencer for the external divider and the fixed-latency multiplier:
// stalls the pipe while an op runs and presents {hi,lo} for one cycle.
module muldiv_sched
    import alu_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    input  muldiv_op_t      req_op_i,
    input  logic [DW-1:0]   req_a_i,
    input  logic [DW-1:0]   req_b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            result_valid_o,
    output logic [2*DW-1:0] hilo_o,
    output logic            div_by_zero_o,
    output logic            mul_en_o,
    output logic            mul_signed_o,
    output logic [DW-1:0]   mul_a_o,
    output logic [DW-1:0]   mul_b_o,
    input  logic [2*DW-1:0] mul_res_i,
    output logic            div_start_o,
    output logic            div_signed_o,
    output logic            div_annul_o,
    output logic [DW-1:0]   div_a_o,
    output logic [DW-1:0]   div_b_o,
    input  logic [2*DW-1:0] div_res_i,
    input  logic            div_ready_i
);

    localparam int unsigned RW = 2 * DW;
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    muldiv_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] a_q, b_q;
    logic [RW-1:0] res_q;
    logic          signed_q;
    logic          dbz_q;
    logic          accept;
    logic          cap_mul;
    logic          cap_div;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and resource handshakes; flush always wins over progress.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept         = 1'b0;
        cap_mul        = 1'b0;
        cap_div        = 1'b0;
        mul_en_o       = 1'b0;
        div_start_o    = 1'b0;
        div_annul_o    = 1'b0;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    accept  = 1'b1;
                    stall_o = 1'b1;
                    state_d = req_op_i[1] ? ST_DIV : ST_MUL;
                    cnt_d   = CW'(MUL_LAT - 1);
                end
            end
            ST_MUL: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    mul_en_o = 1'b1;
                    stall_o  = 1'b1;
                    if (cnt_q == '0) begin
                        cap_mul = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    div_start_o = 1'b1;
                    stall_o     = 1'b1;
                    if (div_ready_i) begin
                        cap_div = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                result_valid_o = !flush_i;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand, flag and result holding registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            dbz_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            if (accept) begin
                a_q      <= req_a_i;
                b_q      <= req_b_i;
                signed_q <= ~req_op_i[0];
                dbz_q    <= req_op_i[1] & (req_b_i == '0);
            end
            if (cap_mul) begin
                res_q <= mul_res_i;
            end else if (cap_div) begin
                res_q <= div_res_i;
            end
        end
    end

    assign hilo_o        = result_valid_o ? res_q : '0;
    assign div_by_zero_o = dbz_q & result_valid_o;
    assign mul_signed_o  = signed_q;
    assign div_signed_o  = signed_q;
    assign mul_a_o       = a_q;
    assign mul_b_o       = b_q;
    assign div_a_o       = a_q;
    assign div_b_o       = b_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with behavioural multiplier and divider models.
module tb_muldiv_sched;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    muldiv_op_t  req_op = OP_MULT;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic        stall_o, result_valid_o, div_by_zero_o;
    logic [63:0] hilo_o;
    logic        mul_en_o, mul_signed_o;
    logic [31:0] mul_a_o, mul_b_o;
    logic [63:0] mul_res;
    logic        div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_a_o, div_b_o;
    logic [63:0] div_res;
    logic        div_ready;
    logic        force_ready = 1'b0;
    int unsigned div_lat = 1;
    int unsigned dcnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    muldiv_sched #(.DW(32), .MUL_LAT(3)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .flush_i(flush), .stall_o(stall_o), .result_valid_o(result_valid_o),
        .hilo_o(hilo_o), .div_by_zero_o(div_by_zero_o),
        .mul_en_o(mul_en_o), .mul_signed_o(mul_signed_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_res_i(mul_res),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_res_i(div_res), .div_ready_i(div_ready)
    );

    // Multiplier model: full 64-bit product of the latched operands.
    logic signed [63:0] sa, sb;
    always_comb begin
        sa = 64'($signed(mul_a_o));
        sb = 64'($signed(mul_b_o));
        if (mul_signed_o) mul_res = 64'(sa * sb);
        else              mul_res = 64'(mul_a_o) * 64'(mul_b_o);
    end

    // Divider model: {rem,quot}; divide by zero returns {dividend, all ones}.
    always_comb begin
        if (div_b_o == '0)     div_res = {div_a_o, 32'hFFFF_FFFF};
        else if (div_signed_o) div_res = {32'($signed(div_a_o) % $signed(div_b_o)),
                                          32'($signed(div_a_o) / $signed(div_b_o))};
        else                   div_res = {div_a_o % div_b_o, div_a_o / div_b_o};
    end

    always_ff @(posedge clk) begin
        if (div_start_o) dcnt <= dcnt + 1;
        else             dcnt <= 0;
    end
    assign div_ready = force_ready | (div_start_o && (dcnt == div_lat - 1));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else             pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned lat;
        logic [63:0] exp_hilo;
        logic        exp_dbz;
        int unsigned exp_stall;
        logic        exp_signed;
    } vec_t;

    vec_t vecs[8];

    // Runs one op from the IDLE cycle through DONE; returns in the following cycle.
    task automatic run_vec(input vec_t v);
        int unsigned stall_n = 0;
        bit got = 0;
        bit busy_ok = 1;
        logic [63:0] h = '0;
        logic dbz = 1'b0;
        logic sgn = 1'b0;
        logic done_stall = 1'b1;
        div_lat   = v.lat;
        req_valid = 1'b1;
        req_op    = v.op;
        req_a     = v.a;
        req_b     = v.b;
        for (int c = 0; c < 200 && !got; c++) begin
            #3;
            if (result_valid_o) begin
                got        = 1;
                h          = hilo_o;
                dbz        = div_by_zero_o;
                sgn        = v.op[1] ? div_signed_o : mul_signed_o;
                done_stall = stall_o;
            end else begin
                if (stall_o) stall_n++;
                if (c > 0) busy_ok &= v.op[1] ? div_start_o : mul_en_o;
            end
            step();
        end
        req_valid = 1'b0;
        check({v.name, "_done"}, 64'(got), 64'd1);
        check({v.name, "_hilo"}, h, v.exp_hilo);
        check({v.name, "_dbz"}, 64'(dbz), 64'(v.exp_dbz));
        check({v.name, "_stall_cycles"}, 64'(stall_n), 64'(v.exp_stall));
        check({v.name, "_signed"}, 64'(sgn), 64'(v.exp_signed));
        check({v.name, "_busy_handshake"}, 64'(busy_ok), 64'd1);
        check({v.name, "_done_stall"}, 64'(done_stall), 64'd0);
    endtask

    task automatic watch_no_result(input string name, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            #3;
            if (result_valid_o) seen++;
            step();
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         0,  64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 4,  1'b1};
        vecs[1] = '{"multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  64'hFFFF_FFFE_0000_0001, 1'b0, 4,  1'b0};
        vecs[2] = '{"div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         3,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 4,  1'b1};
        vecs[3] = '{"divu_100_7", OP_DIVU,  32'd100,       32'd7,         34, 64'h0000_0002_0000_000E, 1'b0, 35, 1'b0};
        vecs[4] = '{"div_zero",   OP_DIV,   32'd5,         32'd0,         5,  64'h0000_0005_FFFF_FFFF, 1'b1, 6,  1'b1};
        vecs[5] = '{"multu_neg",  OP_MULTU, 32'hFFFF_FFFE, 32'd3,         0,  64'h0000_0002_FFFF_FFFA, 1'b0, 4,  1'b0};
        vecs[6] = '{"divu_big",   OP_DIVU,  32'hFFFF_FFF9, 32'd2,         2,  64'h0000_0001_7FFF_FFFC, 1'b0, 3,  1'b0};
        vecs[7] = '{"mult_m7m7",  OP_MULT,  32'hFFFF_FFF9, 32'hFFFF_FFF9, 0,  64'h0000_0000_0000_0031, 1'b0, 4,  1'b1};

        #2;
        check("reset_ctrl", 64'({stall_o, result_valid_o, div_by_zero_o, mul_en_o, mul_signed_o,
                                 div_start_o, div_signed_o, div_annul_o}), 64'd0);
        check("reset_hilo", hilo_o, 64'd0);
        check("reset_operands", {mul_a_o | div_a_o, mul_b_o | div_b_o}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Table sweep; consecutive vectors are issued back to back.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Flush a divide in its 10th busy cycle.
        div_lat = 34;
        req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7;
        step();
        repeat (9) step();
        req_valid = 1'b0; flush = 1'b1;
        #3;
        check("div_flush_annul", 64'(div_annul_o), 64'd1);
        check("div_flush_start", 64'(div_start_o), 64'd0);
        check("div_flush_stall", 64'(stall_o), 64'd0);
        step();
        flush = 1'b0;
        #3;
        check("div_flush_idle", 64'({stall_o, div_start_o, div_annul_o}), 64'd0);
        step();
        watch_no_result("div_flush_no_result", 40);

        // Flush in the same cycle the divider reports ready.
        div_lat = 50;
        req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd9; req_b = 32'd4;
        step();
        repeat (4) step();
        req_valid = 1'b0; flush = 1'b1; force_ready = 1'b1;
        #3;
        check("flush_ready_annul", 64'(div_annul_o), 64'd1);
        step();
        flush = 1'b0; force_ready = 1'b0;
        watch_no_result("flush_ready_no_result", 10);

        // Flush during the multiply.
        req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd6; req_b = 32'd7;
        step();
        req_valid = 1'b0; flush = 1'b1;
        #3;
        check("mul_flush_en_stall", 64'({mul_en_o, stall_o}), 64'd0);
        step();
        flush = 1'b0;
        watch_no_result("mul_flush_no_result", 8);

        // Flush in the DONE cycle suppresses the result.
        req_valid = 1'b1; req_op = OP_MULTU; req_a = 32'd2; req_b = 32'd3;
        repeat (4) step();
        req_valid = 1'b0; flush = 1'b1;
        #3;
        check("done_flush_valid", 64'(result_valid_o), 64'd0);
        check("done_flush_hilo", hilo_o, 64'd0);
        step();
        flush = 1'b0;
        #3;
        check("done_flush_idle", 64'({stall_o, mul_en_o}), 64'd0);
        step();

        // Flush in IDLE blocks acceptance.
        req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd8; req_b = 32'd2; flush = 1'b1;
        #3;
        check("idle_flush_stall", 64'(stall_o), 64'd0);
        step();
        req_valid = 1'b0; flush = 1'b0;
        #3;
        check("idle_flush_not_started", 64'({stall_o, mul_en_o, div_start_o}), 64'd0);
        step();

        // Asynchronous reset in the middle of a multiply.
        req_valid = 1'b1; req_op = OP_MULT; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
        step();
        req_valid = 1'b0;
        step();
        #2;
        check("pre_reset_busy", 64'({mul_en_o, stall_o}), 64'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({stall_o, result_valid_o, div_by_zero_o, mul_en_o, mul_signed_o,
                                       div_start_o, div_signed_o, div_annul_o}), 64'd0);
        check("async_reset_hilo", hilo_o, 64'd0);
        check("async_reset_operands", {mul_a_o | div_a_o, mul_b_o | div_b_o}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        #3;
        check("post_reset_idle", 64'({stall_o, mul_en_o, div_start_o, result_valid_o}), 64'd0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencing controller for the EX-stage multi-cycle arithmetic resources: the external radix-2 divider (start/annul/ready handshake) and a fixed-latency pipelined multiplier.
- Accepts one MULT/MULTU/DIV/DIVU request from the ALU.
- Holds the pipeline stalled while the operation runs, and delivers the 64-bit {hi,lo} result for exactly one cycle.
- Cancels in-flight work on an exception flush.
- Replaces the ALU's combinational multiply and inline divider enable logic.

Parameters:
- DW, 32, operand width; the result is 2*DW.
- MUL_LAT, 3, multiplier latency in cycles from the first mul_en_o cycle to a valid mul_res_i (>=1).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  EX-stage instruction is a mul/div op.
- req_op_i  in  2  op code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (muldiv_op_t).
- req_a_i  in  DW  reg1 operand (dividend/multiplicand).
- req_b_i  in  DW  reg2 operand (divisor/multiplier).
- flush_i  in  1  exception flush; kills the EX instruction.
- stall_o  out  1  freeze IF..EX stages.
- result_valid_o  out  1  one-cycle pulse; hilo_o is valid.
- hilo_o  out  2*DW  {hi,lo}: div = {remainder,quotient}; mul = product.
- div_by_zero_o  out  1  qualifies result_valid_o; divisor was 0.
- mul_en_o  out  1  multiplier pipeline advance.
- mul_signed_o  out  1  signed multiply.
- mul_a_o, mul_b_o  out  DW  latched multiplier operands.
- mul_res_i  in  2*DW  multiplier product.
- div_start_o  out  1  divider start; held high until ready.
- div_signed_o  out  1  signed divide.
- div_annul_o  out  1  divider cancel.
- div_a_o, div_b_o  out  DW  latched divider operands.
- div_res_i  in  2*DW  divider result {rem,quot}.
- div_ready_i  in  1  divider result valid.

Behaviour:
- States (muldiv_state_t): IDLE, MUL, DIV, DONE.
- Reset (rst_ni low, async): state IDLE, all operand/result registers 0, cnt 0. All outputs 0.
- IDLE:
  - A request is accepted when req_valid_i & !flush_i.
  - On accept, latch the operands, latch the signed flag (signed = !req_op_i[0]), and latch div_by_zero = req_op_i[1] & (req_b_i==0).
  - Next state is MUL (cnt <= MUL_LAT-1) or DIV, selected by req_op_i[1].
  - With flush_i high the request is ignored and the state stays IDLE.
- stall_o (combinational): (IDLE & req_valid_i & !flush_i) | state==MUL | state==DIV. It is low in DONE, so the held instruction leaves EX in the DONE cycle.
- MUL:
  - mul_en_o=1; cnt decrements each cycle.
  - When cnt==0, capture mul_res_i into the result register and go to DONE.
  - Total stall is MUL_LAT+1 cycles: the acceptance cycle plus MUL_LAT.
- DIV:
  - div_start_o=1 every cycle in DIV.
  - On div_ready_i, capture div_res_i and go to DONE.
  - Divide by zero still waits for div_ready_i; the result is whatever the divider returns, flagged by div_by_zero_o.
- DONE:
  - result_valid_o = !flush_i; hilo_o = the result register.
  - div_by_zero_o = the latched flag & result_valid_o.
  - Next state is IDLE unconditionally.
  - A req_valid_i seen in DONE is the same retiring instruction and is ignored; it is not restarted.
- hilo_o reads 0 whenever result_valid_o is 0.
- Flush in MUL or DIV:
  - Next state is IDLE; no result is produced.
  - In DIV, div_annul_o=1 and div_start_o=0 in that cycle.
  - In MUL, mul_en_o=0 in that cycle.
  - stall_o drops in the same cycle (combinational on flush_i).
- Flush and div_ready_i in the same cycle: flush wins; the result is discarded.
- Flush in IDLE or DONE: no state effect beyond suppressing acceptance or result_valid_o.
- Operand registers hold their values until the next acceptance.
- mul_signed_o and div_signed_o are driven from the latched flag.
- Back-to-back requests: a second op is accepted in the IDLE cycle after DONE, giving a minimum 1-cycle gap.
- Result widths:
  - hilo_o[2*DW-1:DW] is hi, hilo_o[DW-1:0] is lo.
  - No truncation or extension is applied; the resources supply full 2*DW results.

Decomposition:
- Shared package alu_pkg:
  - muldiv_op_t (2-bit enum MULT/MULTU/DIV/DIVU).
  - muldiv_state_t (IDLE/MUL/DIV/DONE).
  - Constant MUL_LAT_DEFAULT.
- The ALU maps aluop_i to muldiv_op_t.
- Single module; no sub-module. The multiplier and the divider stay external instances wired in EX.

Test Plan:
- MULT a=0xFFFFFFFE, b=3, MUL_LAT=3 -> stall_o high 4 cycles; result_valid_o 1 cycle; hilo_o=0xFFFFFFFF_FFFFFFFA; mul_signed_o=1.
- DIVU a=100, b=7, with the divider model replying ready after 34 cycles -> div_start_o held high until ready; hilo_o={2,14}; stall_o low in the DONE cycle; div_by_zero_o=0.
- DIV a=5, b=0 -> div_by_zero_o=1 with result_valid_o.
- DIV in flight, flush_i at cycle 10 -> div_annul_o=1 that cycle; div_start_o=0; stall_o=0 that cycle; state IDLE next cycle; result_valid_o never asserts.
- Flush coincident with div_ready_i -> no result_valid_o.
- MULTU 0xFFFFFFFF*0xFFFFFFFF followed immediately by DIV -7/2 -> first hilo_o=0xFFFFFFFE_00000001; DIV accepted one cycle after DONE; second hilo_o={0xFFFFFFFF,0xFFFFFFFD}.
- rst_ni deasserted-low during MUL -> all outputs 0 asynchronously; after release, state IDLE and stall_o=0 with req_valid_i low.
